// File: rtl/result_fifo_ctrl_if.sv
// Bus between the result FIFO controller (master) and the plate-result FIFO RAM buffer (slave).
interface result_fifo_ctrl_if #(
    parameter int W = 32
);
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_clear;
    logic [W-1:0] fifo_data;
    logic [W-1:0] fifo_q;
    logic         fifo_error;

    modport master (
        output fifo_push, fifo_pop, fifo_clear, fifo_data,
        input  fifo_q, fifo_error
    );

    modport slave (
        input  fifo_push, fifo_pop, fifo_clear, fifo_data,
        output fifo_q, fifo_error
    );
endinterface

// File: rtl/result_fifo_ctrl.sv
// Plate-result FIFO controller: round-robin producer push arbiter, host read
// pop/fetch FSM, buffer clear and shadow occupancy tracking.
module result_fifo_ctrl #(
    parameter int PIO_DATA_WIDTH   = 32,
    parameter int RESULT_RAM_DEPTH = 16,
    parameter int NUM_REQ          = 4,
    parameter int READ_LAT         = 2
) (
    input  logic                                clk_in,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  prod_req,
    input  logic [NUM_REQ*PIO_DATA_WIDTH-1:0]   prod_data,
    output logic [NUM_REQ-1:0]                  prod_ack,
    result_fifo_ctrl_if.master                  fifo,
    input  logic                                host_rd_req,
    input  logic                                host_clear,
    output logic [PIO_DATA_WIDTH-1:0]           host_rd_data,
    output logic                                host_rd_valid,
    output logic                                host_rd_empty,
    output logic [$clog2(RESULT_RAM_DEPTH):0]   level,
    output logic                                full,
    output logic                                empty,
    output logic                                err_sticky,
    output logic [1:0]                          rd_state_dbg
);
    localparam int LW = $clog2(RESULT_RAM_DEPTH) + 1;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    // Handshakes: producers hold prod_req until a one-cycle prod_ack, which
    // coincides with fifo_push; the host issues one-cycle pulses on
    // host_rd_req/host_clear and gets a one-cycle host_rd_valid or
    // host_rd_empty answer (none for a dropped or aborted read).

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_POP   = 2'd2
    } rd_state_e;

    rd_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;
    logic          clear_cycle;
    logic          pop_go;
    logic          empty_go;

    assign full         = (level == LW'(RESULT_RAM_DEPTH - 1));
    assign empty        = (level == '0);
    assign rd_state_dbg = state_q;

    // First asserted request at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && prod_req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        if (full || clear_cycle || !rst_n) begin
            grant_vld = 1'b0;
        end
    end

    assign prod_ack       = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    assign fifo.fifo_push = grant_vld;
    assign fifo.fifo_data = grant_vld ? prod_data[int'(grant_idx)*PIO_DATA_WIDTH +: PIO_DATA_WIDTH] : '0;
    assign fifo.fifo_clear = clear_cycle;
    assign fifo.fifo_pop  = pop_go;

    always_comb begin
        state_d  = state_q;
        pop_go   = 1'b0;
        empty_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_rd_req) begin
                    if (level != '0) begin
                        state_d = ST_FETCH;
                    end else begin
                        empty_go = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (cnt_q == CW'(READ_LAT - 1)) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                pop_go  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A clear aborts any read silently.
        if (clear_cycle) begin
            state_d  = ST_IDLE;
            pop_go   = 1'b0;
            empty_go = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rr_ptr        <= '0;
            clear_cycle   <= 1'b0;
            level         <= '0;
            err_sticky    <= 1'b0;
            host_rd_data  <= '0;
            host_rd_valid <= 1'b0;
            host_rd_empty <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= (state_q == ST_FETCH) ? cnt_q + 1'b1 : '0;
            clear_cycle   <= host_clear;
            host_rd_valid <= pop_go;
            host_rd_empty <= empty_go;
            if (pop_go) begin
                host_rd_data <= fifo.fifo_q;
            end
            if (clear_cycle) begin
                level      <= '0;
                rr_ptr     <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (grant_vld) begin
                    rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                end
                if (grant_vld && !pop_go) begin
                    level <= level + 1'b1;
                end else if (!grant_vld && pop_go && level != '0) begin
                    level <= level - 1'b1;
                end
                if (fifo.fifo_error) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_result_fifo_ctrl.sv
// Directed bench for result_fifo_ctrl: cycle table for arbitration/reset/clear/error,
// hand sequences for full stall, ordered reads, empty read and clear during fetch.
module tb_result_fifo_ctrl;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic [N-1:0]   prod_req;
    logic [N*W-1:0] prod_data;
    logic [N-1:0]   prod_ack;
    logic           host_rd_req;
    logic           host_clear;
    logic [W-1:0]   host_rd_data;
    logic           host_rd_valid;
    logic           host_rd_empty;
    logic [4:0]     level;
    logic           full;
    logic           empty;
    logic           err_sticky;
    logic [1:0]     rd_state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    result_fifo_ctrl_if #(.W(W)) fifo_bus ();

    result_fifo_ctrl #(
        .PIO_DATA_WIDTH(W), .RESULT_RAM_DEPTH(16), .NUM_REQ(N), .READ_LAT(2)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .prod_req(prod_req), .prod_data(prod_data), .prod_ack(prod_ack),
        .fifo(fifo_bus),
        .host_rd_req(host_rd_req), .host_clear(host_clear),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .host_rd_empty(host_rd_empty), .level(level), .full(full),
        .empty(empty), .err_sticky(err_sticky), .rd_state_dbg(rd_state_dbg)
    );

    // Clock and reset
    always #5 clk_in = ~clk_in;

    // FIFO RAM stand-in
    logic [W-1:0] mem [16];
    logic [3:0]   wp, rp;
    int           pop_cnt = 0;
    assign fifo_bus.fifo_q = mem[rp];
    always @(posedge clk_in) begin
        if (!rst_n || fifo_bus.fifo_clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (fifo_bus.fifo_push) begin
                mem[wp] <= fifo_bus.fifo_data;
                wp      <= wp + 1'b1;
            end
            if (fifo_bus.fifo_pop) begin
                rp      <= rp + 1'b1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    // Driver / check tasks
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic to_check();
        @(negedge clk_in);
    endtask

    task automatic to_next();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) prod_data[i*W +: W] = 32'hA5A5_0001 + i;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        prod_req = '0;
        host_rd_req = 1'b0;
        host_clear = 1'b0;
        fifo_bus.fifo_error = 1'b0;
        set_default_data();
        repeat (2) to_next();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         clr;
        logic         err;
        logic [N-1:0] ack;
        logic         clr_o;
        logic [4:0]   lvl;
        logic         errs;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic rst, input logic [N-1:0] req, input logic clr,
                                input logic err, input logic [N-1:0] ack, input logic clr_o,
                                input logic [4:0] lvl, input logic errs, input logic [W-1:0] data);
        vec_t v;
        v.rst = rst; v.req = req; v.clr = clr; v.err = err; v.ack = ack;
        v.clr_o = clr_o; v.lvl = lvl; v.errs = errs; v.data = data;
        return v;
    endfunction

    logic [W-1:0] exp_q[$];
    int           pops_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst req clr err | ack clr_o lvl errs data
        tbl[0]  = mk(0, 4'b0001, 0, 0, 4'b0001, 0, 0, 0, 32'hA5A5_0001);
        tbl[1]  = mk(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 32'h0);
        tbl[2]  = mk(1, 4'b1111, 0, 0, 4'b0000, 0, 1, 0, 32'h0);
        tbl[3]  = mk(0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 32'hA5A5_0001);
        tbl[4]  = mk(0, 4'b1111, 0, 0, 4'b0010, 0, 1, 0, 32'hA5A5_0002);
        tbl[5]  = mk(0, 4'b1111, 0, 0, 4'b0100, 0, 2, 0, 32'hA5A5_0003);
        tbl[6]  = mk(0, 4'b1111, 0, 0, 4'b1000, 0, 3, 0, 32'hA5A5_0004);
        tbl[7]  = mk(0, 4'b1111, 0, 0, 4'b0001, 0, 4, 0, 32'hA5A5_0001);
        tbl[8]  = mk(0, 4'b1111, 0, 0, 4'b0010, 0, 5, 0, 32'hA5A5_0002);
        tbl[9]  = mk(0, 4'b1111, 0, 0, 4'b0100, 0, 6, 0, 32'hA5A5_0003);
        tbl[10] = mk(0, 4'b1111, 0, 0, 4'b1000, 0, 7, 0, 32'hA5A5_0004);
        tbl[11] = mk(0, 4'b0000, 0, 0, 4'b0000, 0, 8, 0, 32'h0);
        tbl[12] = mk(0, 4'b0000, 0, 1, 4'b0000, 0, 8, 0, 32'h0);
        tbl[13] = mk(0, 4'b0000, 0, 0, 4'b0000, 0, 8, 1, 32'h0);
        tbl[14] = mk(0, 4'b0000, 1, 0, 4'b0000, 0, 8, 1, 32'h0);
        tbl[15] = mk(0, 4'b1111, 0, 1, 4'b0000, 1, 8, 1, 32'h0);
        tbl[16] = mk(0, 4'b1111, 0, 0, 4'b0001, 0, 0, 0, 32'hA5A5_0001);
        tbl[17] = mk(0, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 32'h0);

        to_next();
        do_reset();

        // Reset state
        to_check();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_rd_data", host_rd_data, 0);
        chk("rst_rd_valid", host_rd_valid, 0);
        chk("rst_rd_empty", host_rd_empty, 0);
        chk("rst_push_pop_clr", {fifo_bus.fifo_push, fifo_bus.fifo_pop, fifo_bus.fifo_clear}, 0);
        chk("rst_state", rd_state_dbg, 0);
        to_next();

        // Table: single push, reset mid-push, round robin, error sticky, clear
        for (int i = 0; i < 18; i++) begin
            rst_n = ~tbl[i].rst;
            prod_req = tbl[i].req;
            host_clear = tbl[i].clr;
            fifo_bus.fifo_error = tbl[i].err;
            to_check();
            chk($sformatf("tbl%0d_ack", i), prod_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_push", i), fifo_bus.fifo_push, |tbl[i].ack);
            chk($sformatf("tbl%0d_fifo_clear", i), fifo_bus.fifo_clear, tbl[i].clr_o);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].lvl == 0);
            chk($sformatf("tbl%0d_err_sticky", i), err_sticky, tbl[i].errs);
            chk($sformatf("tbl%0d_pop", i), fifo_bus.fifo_pop, 0);
            if (|tbl[i].ack) chk($sformatf("tbl%0d_data", i), fifo_bus.fifo_data, tbl[i].data);
            to_next();
        end
        rst_n = 1'b1;
        prod_req = '0;
        host_clear = 1'b0;
        fifo_bus.fifo_error = 1'b0;

        // Fill to full, stall, one read releases the stalled producer
        do_reset();
        prod_req = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            prod_data[0 +: W] = 32'h3000 + i;
            to_check();
            chk($sformatf("fill%0d_ack", i), prod_ack, 4'b0001);
            to_next();
        end
        prod_data[0 +: W] = 32'h30FF;
        host_rd_req = 1'b1;
        to_check();
        chk("full_flag", full, 1);
        chk("full_level", level, 15);
        chk("full_no_ack", prod_ack, 0);
        chk("full_no_push", fifo_bus.fifo_push, 0);
        to_next();
        host_rd_req = 1'b0;
        to_check(); chk("full_rd_fetch0_pop", fifo_bus.fifo_pop, 0); to_next();
        to_check(); chk("full_rd_fetch1_pop", fifo_bus.fifo_pop, 0); to_next();
        to_check();
        chk("full_rd_pop", fifo_bus.fifo_pop, 1);
        chk("full_rd_pop_no_ack", prod_ack, 0);
        to_next();
        to_check();
        chk("full_rd_valid", host_rd_valid, 1);
        chk("full_rd_data", host_rd_data, 32'h3000);
        chk("full_level_after_pop", level, 14);
        chk("stalled_ack", prod_ack, 4'b0001);
        chk("stalled_data", fifo_bus.fifo_data, 32'h30FF);
        to_next();
        prod_req = '0;

        // Ordered reads, a dropped mid-read request, then a read of empty
        do_reset();
        prod_req = 4'b0001;
        for (int i = 1; i <= 3; i++) begin
            prod_data[0 +: W] = 32'h11 * i;
            exp_q.push_back(32'h11 * i);
            to_check();
            chk($sformatf("push%0d_ack", i), prod_ack, 4'b0001);
            to_next();
        end
        prod_req = '0;
        pops_before = pop_cnt;
        for (int r = 0; r < 4; r++) begin
            host_rd_req = 1'b1;
            to_check();
            if (r > 0) begin
                chk($sformatf("rd%0d_valid", r - 1), host_rd_valid, 1);
                chk($sformatf("rd%0d_data", r - 1), host_rd_data, exp_q.pop_front());
            end else begin
                chk("rd_level_before", level, 3);
            end
            to_next();
            host_rd_req = 1'b0;
            if (r == 3) break;
            to_check();
            chk($sformatf("rd%0d_fetch_state", r), rd_state_dbg, 1);
            chk($sformatf("rd%0d_fetch_pop", r), fifo_bus.fifo_pop, 0);
            to_next();
            host_rd_req = 1'b1;
            to_check(); chk($sformatf("rd%0d_dropped_pop", r), fifo_bus.fifo_pop, 0); to_next();
            host_rd_req = 1'b0;
            to_check();
            chk($sformatf("rd%0d_pop", r), fifo_bus.fifo_pop, 1);
            chk($sformatf("rd%0d_pop_state", r), rd_state_dbg, 2);
            to_next();
        end
        to_check();
        chk("rd_empty_pulse", host_rd_empty, 1);
        chk("rd_empty_no_pop", fifo_bus.fifo_pop, 0);
        to_next();
        for (int i = 0; i < 3; i++) begin
            to_check();
            chk($sformatf("rd_empty_after%0d", i),
                {fifo_bus.fifo_pop, host_rd_valid, host_rd_empty}, 0);
            to_next();
        end
        chk("rd_pop_count", pop_cnt - pops_before, 3);

        // Clear during FETCH aborts the read and resets the round-robin pointer
        do_reset();
        prod_req = 4'b1111;
        repeat (5) to_next();
        prod_req = '0;
        host_rd_req = 1'b1;
        to_check();
        chk("clr_level_before", level, 5);
        to_next();
        host_rd_req = 1'b0;
        host_clear = 1'b1;
        pops_before = pop_cnt;
        to_check(); chk("clr_fetch_state", rd_state_dbg, 1); to_next();
        host_clear = 1'b0;
        to_check();
        chk("clr_fifo_clear", fifo_bus.fifo_clear, 1);
        chk("clr_no_pop", fifo_bus.fifo_pop, 0);
        to_next();
        prod_req = 4'b1111;
        to_check();
        chk("clr_one_cycle", fifo_bus.fifo_clear, 0);
        chk("clr_level", level, 0);
        chk("clr_state_idle", rd_state_dbg, 0);
        chk("clr_rr_ack", prod_ack, 4'b0001);
        chk("clr_no_pop2", fifo_bus.fifo_pop, 0);
        to_next();
        prod_req = '0;
        for (int i = 0; i < 3; i++) begin
            to_check();
            chk($sformatf("clr_no_valid%0d", i), host_rd_valid, 0);
            to_next();
        end
        chk("clr_level_after", level, 1);
        chk("clr_pop_count", pop_cnt - pops_before, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/result_fifo_ctrl.md
Name: result_fifo_ctrl

Overview:
Controller sequencing the plate-result FIFO, a circular dual-port RAM buffer with push, pop and clear strobes, registered read data and a one-slot-empty full rule. It round-robin arbitrates NUM_REQ result producers onto the single push port. It serves host PIO read requests through a pop/fetch state machine and owns the buffer clear. It keeps a shadow occupancy count so the FIFO's own error output never fires in normal operation.

Parameters:
PIO_DATA_WIDTH, 32, result word width.
RESULT_RAM_DEPTH, 16, FIFO RAM depth; usable capacity is RESULT_RAM_DEPTH-1.
NUM_REQ, 4, number of result producers.
READ_LAT, 2, cycles from the head becoming stable to fifo_q being valid.

Ports:
clk_in  in  1  clock
rst_n  in  1  synchronous active-low reset
prod_req  in  NUM_REQ  per-producer push request, level, held until ack
prod_data  in  NUM_REQ*PIO_DATA_WIDTH  producer i data at bits [i*W +: W]
prod_ack  out  NUM_REQ  one-hot 1-cycle pulse; word accepted
fifo_push  out  1  FIFO push strobe
fifo_pop  out  1  FIFO pop strobe
fifo_clear  out  1  FIFO Clear_buff strobe
fifo_data  out  PIO_DATA_WIDTH  FIFO write data
fifo_q  in  PIO_DATA_WIDTH  FIFO head data
fifo_error  in  1  FIFO error flag
host_rd_req  in  1  host read request, 1-cycle pulse
host_clear  in  1  host clear request, 1-cycle pulse
host_rd_data  out  PIO_DATA_WIDTH  last popped word, held
host_rd_valid  out  1  1-cycle pulse; host_rd_data updated
host_rd_empty  out  1  1 when the read FSM returns nothing (read of empty)
level  out  $clog2(RESULT_RAM_DEPTH)+1  shadow occupancy
full  out  1  level==RESULT_RAM_DEPTH-1
empty  out  1  level==0
err_sticky  out  1  latched fifo_error

Behaviour:
- Reset (rst_n low at a clk_in edge):
  - all outputs 0; level 0, so empty=1.
  - RR pointer 0; read FSM IDLE; host_rd_data 0.
- Push arbiter:
  - Each cycle, if !full and !clear_cycle, grant the first asserted prod_req starting at rr_ptr, wrapping modulo NUM_REQ.
  - On a grant: fifo_push=1, fifo_data=prod_data[g], prod_ack[g]=1, all combinational in the same cycle; next rr_ptr=(g+1)%NUM_REQ.
  - No grant: push, ack and rr_ptr are unchanged.
  - When full, no grant is given and requesters stall.
- Read FSM:
  - IDLE: on host_rd_req, if level>0 go to FETCH with a counter cleared to 0. If level==0, pulse host_rd_empty next cycle and stay in IDLE.
  - FETCH: the counter increments each cycle. When counter==READ_LAT-1, go to POP.
  - POP: capture fifo_q into host_rd_data, fifo_pop=1 for exactly this cycle, host_rd_valid=1 the following cycle, then return to IDLE.
  - host_rd_req outside IDLE is ignored (dropped).
  - Read-to-read throughput is READ_LAT+2 cycles.
- Level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. It never exceeds RESULT_RAM_DEPTH-1 and never underflows.
- Clear:
  - host_clear causes fifo_clear=1 in the next cycle (clear_cycle).
  - In clear_cycle: no push, no pop, no ack; level←0; rr_ptr←0; read FSM←IDLE without valid; err_sticky←0.
  - A read in flight is aborted silently.
  - Clear beats fifo_error in the same cycle.
- err_sticky sets on fifo_error=1 and holds until clear or reset.
- Reset asserted mid-read or mid-push: FSM to IDLE, no pulses on the next cycle.

Test Plan:
1. Reset, then prod_req=4'b0001 with data 0xA5A5_0001 held one cycle → prod_ack[0] and fifo_push in the same cycle, fifo_data=0xA5A5_0001, level=1, empty=0.
2. All four prod_req high for 8 cycles → acks in order 0,1,2,3,0,1,2,3, level=8.
3. Push 15 words → full=1, the 16th request gets no ack and no push. Then one host read: pop at FETCH+2, host_rd_valid one cycle after the pop, and the stalled request is acked the cycle after level drops to 14.
4. Push 0x11, 0x22, 0x33, then three reads spaced 4 cycles apart → host_rd_data=0x11, 0x22, 0x33 with one valid pulse each; a fourth read → host_rd_empty pulse, no pop.
5. Push 5 words, start a read, host_clear during FETCH → fifo_clear one cycle, no valid, level=0, next prod_req acked with rr_ptr at 0.
6. Force fifo_error=1 for one cycle → err_sticky=1 and held; host_clear → err_sticky=0.
